ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port replacement RAM between the CPU-side bus interface and the diagnostics SPI engine.
- Serialises the two requesters into one RAM port through a 3-state access FSM.
- Priority depends on the CPU halt line: diagnostics wins while the CPU is halted. While the CPU runs, the CPU wins, but a starvation counter guarantees diagnostics a slot.
- Sits between the bus/diagnostics blocks and the RAM macro. The macro is synchronous, with read data valid the cycle after cs.

Parameters:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DIAG_MAX_WAIT, 4, max consecutive CPU grants while diag_req is pending before diag is forced (range 1..15).

Ports:
- fpga_clk  in  1  system clock; all logic on the rising edge.
- fpga_reset  in  1  asynchronous, active-low reset.
- halt  in  1  CPU halted; selects diag priority.
- cpu_req  in  1  CPU access request; held with operands until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdata  out  DATA_WIDTH  CPU read data; valid with cpu_ack, held until the next CPU read.
- cpu_ack  out  1  one-cycle completion pulse.
- diag_req, diag_we, diag_addr, diag_wdata, diag_rdata, diag_ack: same set and semantics for the diagnostics port.
- ram_cs  out  1  RAM select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- owner  out  2  current grant: 00 none, 01 CPU, 10 diag.

Behaviour:
- Reset (async, fpga_reset=0): state IDLE; all outputs 0 (rdata registers, acks, ram_*, owner); starvation counter 0. Takes effect immediately, including mid-access; the interrupted access is dropped with no ack.
- States: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE, arbitration at each edge:
  - Only one requester active: that one wins.
  - Both active, halt=1: diag wins.
  - Both active, halt=0: CPU wins, unless the starvation counter == DIAG_MAX_WAIT, in which case diag wins.
- IDLE with a winner: latch its addr/we/wdata onto ram_addr/ram_we/ram_wdata; ram_cs<=1; owner<=winner; go to ACCESS.
- IDLE with no request: stay; ram_cs=0, owner=00.
- ACCESS (ram_cs=1 for exactly this one cycle):
  - ram_cs<=0, ram_we<=0.
  - Go to DONE.
- DONE:
  - Read: winner's rdata <= ram_rdata.
  - Write: winner's rdata unchanged.
  - Winner's ack<=1 for one cycle; owner<=00; go to IDLE.
- Latency: req sampled high in IDLE -> ack high 3 edges later. Back-to-back throughput is 1 access per 3 cycles.
- Requester handshake: req must drop on the edge where ack is sampled. A req still high in the following IDLE is treated as a new request.
- Starvation counter:
  - Increments on a CPU grant made while diag_req=1, saturating at DIAG_MAX_WAIT.
  - Clears on any diag grant.
  - Clears on a CPU grant made while diag_req=0.
- halt changing during ACCESS/DONE does not abort the in-flight access; it affects the next arbitration only.
- Operands are taken only in IDLE; changes during ACCESS/DONE are ignored.
- Address wrap: no address arithmetic in this block; 16'hFFFF is passed through unchanged.
- Never: both acks high in the same cycle, or ram_cs high for two consecutive cycles.

Optional Feature:
- Macro: ARB_STATS_EN.
- With ARB_STATS_EN defined:
  - Adds input stats_clear (1) and outputs cpu_grants (16) and diag_grants (16).
  - Each counter increments on its requester's ack and saturates at 16'hFFFF.
  - stats_clear=1 zeroes both counters synchronously and overrides a same-cycle increment.
  - Reset value 0.
- Without ARB_STATS_EN: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- CPU write then read:
  - cpu write addr 16'h1234 data 8'hA5 -> ram_cs=1, ram_we=1, ram_addr=16'h1234 for one cycle; cpu_ack 3 edges after req.
  - cpu read of the same address -> cpu_rdata=8'hA5 with cpu_ack.
- Simultaneous requests with halt=1, cpu addr 16'h0010, diag addr 16'h0020:
  - Diag served first (ram_addr=16'h0020, owner=10).
  - CPU served in the next access cycle.
  - No overlapping acks.
- Starvation with halt=0, DIAG_MAX_WAIT=4: cpu_req continuously re-asserted, diag_req held -> exactly 4 CPU grants, then 1 diag grant, then CPU resumes.
- Reset mid-operation: assert fpga_reset=0 during ACCESS -> all outputs 0 immediately, no ack; after release, a fresh diag read completes normally.
- halt toggle mid-access: CPU access in flight and halt rises in ACCESS -> CPU access completes with cpu_ack; the subsequent contended arbitration goes to diag.
- ARB_STATS_EN:
  - 3 CPU + 2 diag accesses -> cpu_grants=3, diag_grants=2.
  - stats_clear pulse -> both counters 0.
  - Preload near saturation -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the CPU bus port and the diagnostics SPI port onto one synchronous single-port RAM.
// Optional grant statistics counters are compiled in when ARB_STATS_EN is defined.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int DIAG_MAX_WAIT = 4
) (
  input  logic                  fpga_clk,
  input  logic                  fpga_reset,
  input  logic                  halt,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  diag_req,
  input  logic                  diag_we,
  input  logic [ADDR_WIDTH-1:0] diag_addr,
  input  logic [DATA_WIDTH-1:0] diag_wdata,
  output logic [DATA_WIDTH-1:0] diag_rdata,
  output logic                  diag_ack,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [1:0]            owner
`ifdef ARB_STATS_EN
  ,
  input  logic                  stats_clear,
  output logic [15:0]           cpu_grants,
  output logic [15:0]           diag_grants
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DIAG = 2'b10
  } owner_e;

  localparam logic [3:0] MAX_WAIT = 4'(DIAG_MAX_WAIT);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [3:0]            starve_q, starve_d;
  logic                  acc_we_q, acc_we_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] diag_rdata_q, diag_rdata_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  diag_ack_q, diag_ack_d;
  logic                  diag_wins;
  logic                  cpu_wins;

  // Diag takes the slot when alone, while halted, or once the CPU has starved it MAX_WAIT times.
  assign diag_wins = diag_req && (!cpu_req || halt || (starve_q == MAX_WAIT));
  assign cpu_wins  = cpu_req && !diag_wins;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    acc_we_d     = acc_we_q;
    ram_cs_d     = ram_cs_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    diag_rdata_d = diag_rdata_q;
    cpu_ack_d    = 1'b0;
    diag_ack_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (diag_wins) begin
          ram_addr_d  = diag_addr;
          ram_we_d    = diag_we;
          ram_wdata_d = diag_wdata;
          acc_we_d    = diag_we;
          ram_cs_d    = 1'b1;
          owner_d     = OWN_DIAG;
          starve_d    = '0;
          state_d     = ST_ACCESS;
        end else if (cpu_wins) begin
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
          acc_we_d    = cpu_we;
          ram_cs_d    = 1'b1;
          owner_d     = OWN_CPU;
          if (!diag_req)                 starve_d = '0;
          else if (starve_q != MAX_WAIT) starve_d = starve_q + 4'd1;
          state_d     = ST_ACCESS;
        end else begin
          ram_cs_d = 1'b0;
          owner_d  = OWN_NONE;
        end
      end
      ST_ACCESS: begin
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        // The macro has presented read data since the end of the ACCESS cycle.
        if (owner_q == OWN_DIAG) begin
          diag_ack_d = 1'b1;
          if (!acc_we_q) diag_rdata_d = ram_rdata;
        end else begin
          cpu_ack_d = 1'b1;
          if (!acc_we_q) cpu_rdata_d = ram_rdata;
        end
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      starve_q     <= '0;
      acc_we_q     <= 1'b0;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      diag_rdata_q <= '0;
      cpu_ack_q    <= 1'b0;
      diag_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      acc_we_q     <= acc_we_d;
      ram_cs_q     <= ram_cs_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      diag_rdata_q <= diag_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      diag_ack_q   <= diag_ack_d;
    end
  end

  assign ram_cs     = ram_cs_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign diag_rdata = diag_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign diag_ack   = diag_ack_q;
  assign owner      = owner_q;

`ifdef ARB_STATS_EN
  logic [15:0] cpu_grants_q, cpu_grants_d;
  logic [15:0] diag_grants_q, diag_grants_d;

  // Counts land in the same cycle as the ack; clear wins over a coincident increment.
  always_comb begin
    cpu_grants_d  = cpu_grants_q;
    diag_grants_d = diag_grants_q;
    if (stats_clear) begin
      cpu_grants_d  = '0;
      diag_grants_d = '0;
    end else begin
      if (cpu_ack_d && (cpu_grants_q != 16'hFFFF))   cpu_grants_d  = cpu_grants_q + 16'd1;
      if (diag_ack_d && (diag_grants_q != 16'hFFFF)) diag_grants_d = diag_grants_q + 16'd1;
    end
  end

  always_ff @(posedge fpga_clk or negedge fpga_reset) begin
    if (!fpga_reset) begin
      cpu_grants_q  <= '0;
      diag_grants_q <= '0;
    end else begin
      cpu_grants_q  <= cpu_grants_d;
      diag_grants_q <= diag_grants_d;
    end
  end

  assign cpu_grants  = cpu_grants_q;
  assign diag_grants = diag_grants_q;
`endif

endmodule
